// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis between two FWFT FIFOs; one sample every 4 clocks.
// Define IIR_DEEMPH_SAT_EN to clamp the result to DATA_WIDTH instead of wrapping it.
module iir_deemph #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           BITS       = 10,
   parameter logic [DATA_WIDTH-1:0] X_COEFF0   = DATA_WIDTH'(32'h000000B2),
   parameter logic [DATA_WIDTH-1:0] X_COEFF1   = DATA_WIDTH'(32'h000000B2),
   parameter logic [DATA_WIDTH-1:0] Y_COEFF1   = DATA_WIDTH'(32'hFFFFFD66)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic                  x_empty,
   output logic                  x_rd_en,
   output logic [DATA_WIDTH-1:0] y_out,
   input  logic                  y_out_full,
   output logic                  y_wr_en
);

   localparam int unsigned W2 = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_READ, S_MUL, S_ACC, S_WRITE} state_t;

   state_t                        state_q;
   logic signed [DATA_WIDTH-1:0]  x_cur_q;
   logic signed [DATA_WIDTH-1:0]  x_prev_q;
   logic signed [DATA_WIDTH-1:0]  y_prev_q;
   logic signed [DATA_WIDTH-1:0]  y_q;
   logic signed [W2-1:0]          p0_q;
   logic signed [W2-1:0]          p1_q;
   logic signed [W2-1:0]          p2_q;
   logic signed [DATA_WIDTH-1:0]  y_d;

   function automatic logic signed [W2-1:0] sext(input logic [DATA_WIDTH-1:0] v);
      return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
   endfunction

   // Handshakes are combinational so a pop/push lands on the edge that ends the cycle.
   assign x_rd_en = (state_q == S_READ)  && !x_empty    && !reset;
   assign y_wr_en = (state_q == S_WRITE) && !y_out_full && !reset;
   assign y_out   = y_q;

`ifdef IIR_DEEMPH_SAT_EN
   localparam logic signed [W2-1:0] SAT_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [W2-1:0] SAT_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [W2-1:0] sum_c;

   // Each quantisation is a flooring arithmetic shift; clamp before narrowing.
   always_comb begin
      sum_c = ((p0_q + p1_q) >>> BITS) + (p2_q >>> BITS);
      y_d   = sum_c[DATA_WIDTH-1:0];
      if (sum_c > SAT_MAX) begin
         y_d = SAT_MAX[DATA_WIDTH-1:0];
      end else if (sum_c < SAT_MIN) begin
         y_d = SAT_MIN[DATA_WIDTH-1:0];
      end
   end
`else
   // Each quantisation is a flooring arithmetic shift; narrowing wraps.
   always_comb begin
      y_d = DATA_WIDTH'(((p0_q + p1_q) >>> BITS) + (p2_q >>> BITS));
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_READ;
         x_cur_q  <= '0;
         x_prev_q <= '0;
         y_prev_q <= '0;
         y_q      <= '0;
         p0_q     <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
      end else begin
         case (state_q)
            S_READ: begin
               if (x_rd_en) begin
                  x_cur_q <= x_in;
                  state_q <= S_MUL;
               end
            end
            S_MUL: begin
               p0_q    <= sext(X_COEFF0) * sext(x_cur_q);
               p1_q    <= sext(X_COEFF1) * sext(x_prev_q);
               p2_q    <= sext(Y_COEFF1) * sext(y_prev_q);
               state_q <= S_ACC;
            end
            S_ACC: begin
               y_q      <= y_d;
               y_prev_q <= y_d;
               x_prev_q <= x_cur_q;
               state_q  <= S_WRITE;
            end
            S_WRITE: begin
               if (y_wr_en) begin
                  state_q <= S_READ;
               end
            end
            default: state_q <= S_READ;
         endcase
      end
   end

endmodule
